// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined shifter:
//   - MODE_* operation codes (3 bits; 101..111 are reserved)
//   - is_reserved_mode(): true for any code outside SLL/SRL/SRA/ROL/ROR
//   - stage_hdr_t: width-independent part of a stage payload (valid, mode,
//     running carry). The top wraps it with the width-dependent shift amount
//     and data fields to form the full per-stage register.
// -----------------------------------------------------------------------------
package shifter_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef struct packed {
    logic       valid;
    logic [2:0] mode;
    logic       carry;
  } stage_hdr_t;

  function automatic logic is_reserved_mode(input logic [2:0] mode);
    return (mode > MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_level.sv
// -----------------------------------------------------------------------------
// shift_level
// One combinational mux level of the shifter network. When en is set, the
// data is shifted or rotated by 2^K positions according to mode, and the last
// bit moved out of the word (or around it, for rotates) becomes the carry.
// When en is clear, or the mode is reserved, data and carry pass through.
//
// Ports:
//   data_in   [WIDTH-1:0]  operand entering this level
//   carry_in               running carry from earlier levels
//   mode      [2:0]        operation code (shifter_pkg::MODE_*)
//   en                     shift-amount bit K
//   data_out  [WIDTH-1:0]  operand leaving this level
//   carry_out              updated running carry
// -----------------------------------------------------------------------------
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  input  logic [2:0]       mode,
  input  logic             en,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  localparam int N = 1 << K;

  // Carry is the last bit moved out of the current word at this level. Because
  // levels are applied LSB first, the last enabled level decides the final
  // carry, which lands on the required original bit position.
  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    if (en) begin
      case (mode)
        MODE_SLL: begin
          data_out  = data_in << N;
          carry_out = data_in[WIDTH-N];
        end
        MODE_SRL: begin
          data_out  = data_in >> N;
          carry_out = data_in[N-1];
        end
        MODE_SRA: begin
          data_out  = $signed(data_in) >>> N;
          carry_out = data_in[N-1];
        end
        MODE_ROL: begin
          data_out  = (data_in << N) | (data_in >> (WIDTH - N));
          carry_out = data_in[WIDTH-N];
        end
        MODE_ROR: begin
          data_out  = (data_in >> N) | (data_in << (WIDTH - N));
          carry_out = data_in[N-1];
        end
        default: begin
          data_out  = data_in;
          carry_out = carry_in;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
// Pipelined logical/arithmetic shifter and rotator with carry-out and zero
// flags. SHAMT_W mux levels are spread over STAGES register stages, the
// earliest stages taking ceil(SHAMT_W/STAGES) levels each; a stage left
// without levels is a plain register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = adv = !out_valid || out_ready; while adv is high every
// stage loads from its predecessor (bubbles included, never collapsed), and
// while it is low every stage holds, so out_* stay stable under back-pressure.
// Latency is STAGES cycles, throughput one result per cycle.
//
// Ports:
//   clk, rst (async, active-high)
//   in_valid / in_ready, in_data [WIDTH-1:0], in_shamt [SHAMT_W-1:0],
//   in_mode [2:0]
//   out_valid / out_ready, out_data [WIDTH-1:0], out_carry, out_zero, out_err
// -----------------------------------------------------------------------------
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero,
  output logic               out_err
);

  localparam int LPS    = (SHAMT_W + STAGES - 1) / STAGES;  // levels per stage
  localparam int LAST_S = STAGES - 1;

  // Full shift amount travels along; each stage only reads its own bits.
  typedef struct packed {
    stage_hdr_t         hdr;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data;
  } stage_t;

  stage_t stg_in  [STAGES];  // combinational input of stage s
  stage_t stg_out [STAGES];  // combinational result of stage s's levels
  stage_t stg_q   [STAGES];  // register at the end of stage s

  logic adv;
  logic last_zero;
  logic last_err;
  logic zero_q;
  logic err_q;

  assign adv      = !stg_q[LAST_S].hdr.valid || out_ready;
  assign in_ready = adv;

  // Mux levels: the first level of each stage reads that stage's input, the
  // others chain from the previous level.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    localparam int S = k / LPS;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             c_in;
    logic             c_out;

    if (k % LPS == 0) begin : g_head
      assign d_in = stg_in[S].data;
      assign c_in = stg_in[S].hdr.carry;
    end else begin : g_chain
      assign d_in = g_lvl[k-1].d_out;
      assign c_in = g_lvl[k-1].c_out;
    end

    shift_level #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_level (
      .data_in   (d_in),
      .carry_in  (c_in),
      .mode      (stg_in[S].hdr.mode),
      .en        (stg_in[S].shamt[k]),
      .data_out  (d_out),
      .carry_out (c_out)
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * LPS;
    localparam int LAST  = ((s + 1) * LPS < SHAMT_W) ? (s + 1) * LPS - 1 : SHAMT_W - 1;

    if (s == 0) begin : g_src_in
      assign stg_in[s] = '{hdr:   '{valid: in_valid, mode: in_mode, carry: 1'b0},
                           shamt: in_shamt,
                           data:  in_data};
    end else begin : g_src_reg
      assign stg_in[s] = stg_q[s-1];
    end

    if (FIRST < SHAMT_W) begin : g_levels
      assign stg_out[s] = '{hdr:   '{valid: stg_in[s].hdr.valid,
                                     mode:  stg_in[s].hdr.mode,
                                     carry: g_lvl[LAST].c_out},
                            shamt: stg_in[s].shamt,
                            data:  g_lvl[LAST].d_out};
    end else begin : g_pass
      assign stg_out[s] = stg_in[s];
    end
  end

  // Flags are derived from the final-stage result and registered with it.
  assign last_zero = (stg_out[LAST_S].data == '0);
  assign last_err  = is_reserved_mode(stg_out[LAST_S].hdr.mode);

  // Payload is loaded only with a valid operation so that bubbles leave the
  // previous result (and its flags) untouched on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_q[s] <= '0;
      end
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        if (stg_out[s].hdr.valid) begin
          stg_q[s] <= stg_out[s];
        end else begin
          stg_q[s].hdr.valid <= 1'b0;
        end
      end
      if (stg_out[LAST_S].hdr.valid) begin
        zero_q <= last_zero;
        err_q  <= last_err;
      end
    end
  end

  assign out_valid = stg_q[LAST_S].hdr.valid;
  assign out_data  = stg_q[LAST_S].data;
  assign out_carry = stg_q[LAST_S].hdr.carry;
  assign out_zero  = zero_q;
  assign out_err   = err_q;

  // Mode and shift amount are fully consumed before the output register.
  logic unused_last;
  assign unused_last = ^{stg_q[LAST_S].hdr.mode, stg_q[LAST_S].shamt};

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGES  = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data  = '0;
  logic [SHAMT_W-1:0] in_shamt = '0;
  logic [2:0]         in_mode  = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;
  logic               out_err;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_shifter #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
    n_cmp++; if (out_carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b expected 0", out_carry); end
    n_cmp++; if (out_zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b expected 0", out_zero); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", out_err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  // Single operation into an empty pipeline; entered and left at posedge+1.
  task automatic test_op(input string name, input logic [31:0] d, input logic [4:0] sh,
                         input logic [2:0] m, input logic [31:0] ed, input logic ec,
                         input logic ez, input logic ee);
    out_ready = 1'b1;
    in_valid  = 1'b1; in_data = d; in_shamt = sh; in_mode = m;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s early_valid: got %b expected 0", name, out_valid); end
    @(posedge clk); #2;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s valid: got %b expected 1", name, out_valid); end
    n_cmp++; if (out_data !== ed) begin n_bad++; $display("FAIL %s data: got %h expected %h", name, out_data, ed); end
    n_cmp++; if (out_carry !== ec) begin n_bad++; $display("FAIL %s carry: got %b expected %b", name, out_carry, ec); end
    n_cmp++; if (out_zero !== ez) begin n_bad++; $display("FAIL %s zero: got %b expected %b", name, out_zero, ez); end
    n_cmp++; if (out_err !== ee) begin n_bad++; $display("FAIL %s err: got %b expected %b", name, out_err, ee); end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    test_op("sra_1",     32'hFFFFFFFD, 5'd1,  MODE_SRA, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    test_op("sll_1",     32'h80000001, 5'd1,  MODE_SLL, 32'h00000002, 1'b1, 1'b0, 1'b0);
    test_op("srl_1",     32'h00000001, 5'd1,  MODE_SRL, 32'h00000000, 1'b1, 1'b1, 1'b0);
    test_op("ror_1",     32'h00000001, 5'd1,  MODE_ROR, 32'h80000000, 1'b1, 1'b0, 1'b0);
    test_op("rol_4",     32'h80000000, 5'd4,  MODE_ROL, 32'h00000008, 1'b0, 1'b0, 1'b0);
    test_op("sra_0",     32'hA5A5A5A5, 5'd0,  MODE_SRA, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    test_op("sll_0",     32'h80000001, 5'd0,  MODE_SLL, 32'h80000001, 1'b0, 1'b0, 1'b0);
    test_op("sll_31",    32'h00000003, 5'd31, MODE_SLL, 32'h80000000, 1'b1, 1'b0, 1'b0);
    test_op("sra_31",    32'hC0000000, 5'd31, MODE_SRA, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    test_op("rol_8",     32'h12345678, 5'd8,  MODE_ROL, 32'h34567812, 1'b0, 1'b0, 1'b0);
    test_op("ror_4",     32'h12345678, 5'd4,  MODE_ROR, 32'h81234567, 1'b1, 1'b0, 1'b0);
    test_op("srl_30",    32'hE0000000, 5'd30, MODE_SRL, 32'h00000003, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reserved();
    test_op("rsv_110",   32'h12345678, 5'd0,  3'b110,   32'h12345678, 1'b0, 1'b0, 1'b1);
    test_op("rsv_111",   32'h0000F00F, 5'd5,  3'b111,   32'h0000F00F, 1'b0, 1'b0, 1'b1);
    test_op("err_clear", 32'h00000010, 5'd4,  MODE_SRL, 32'h00000001, 1'b0, 1'b0, 1'b0);
  endtask

  // Three consecutive operations with out_ready high: results on consecutive cycles.
  task automatic test_back_to_back();
    logic [31:0] vd [3];
    logic [4:0]  vs [3];
    logic [2:0]  vm [3];
    logic [31:0] ed [3];
    logic        ec [3];
    vd[0] = 32'h00000001; vs[0] = 5'd1; vm[0] = MODE_ROR; ed[0] = 32'h80000000; ec[0] = 1'b1;
    vd[1] = 32'h00000001; vs[1] = 5'd4; vm[1] = MODE_SLL; ed[1] = 32'h00000010; ec[1] = 1'b0;
    vd[2] = 32'h80000000; vs[2] = 5'd4; vm[2] = MODE_SRA; ed[2] = 32'hF8000000; ec[2] = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin in_data = vd[c]; in_shamt = vs[c]; in_mode = vm[c]; end
      #1;
      if (c >= 2 && c <= 4) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c - 2, out_valid); end
        n_cmp++; if (out_data !== ed[c-2]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", c - 2, out_data, ed[c-2]); end
        n_cmp++; if (out_carry !== ec[c-2]) begin n_bad++; $display("FAIL b2b_carry[%0d]: got %b expected %b", c - 2, out_carry, ec[c-2]); end
      end else if (c == 5) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail_valid: got %b expected 0", out_valid); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Four SLL ops (data=1, shamt=0..3), out_ready low in cycles 3..6.
  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int          sent = 0;
    int          got = 0;
    logic        held = 1'b0;
    logic        stall_seen = 1'b0;
    logic [31:0] hd;
    logic        hc, hz, he;
    hd = '0; hc = 1'b0; hz = 1'b0; he = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 4);
      in_data   = 32'h1;
      in_shamt  = 5'(sent);
      in_mode   = MODE_SLL;
      #1;
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hd || out_carry !== hc || out_zero !== hz || out_err !== he) begin
          n_bad++;
          $display("FAIL bp_stable: got v=%b d=%h c=%b z=%b e=%b expected v=1 d=%h c=%b z=%b e=%b",
                   out_valid, out_data, out_carry, out_zero, out_err, hd, hc, hz, he);
        end
      end
      if (out_valid && !out_ready) begin
        stall_seen = 1'b1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bp_extra: got %h expected no result", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          n_cmp++; if (out_data !== exp_v) begin n_bad++; $display("FAIL bp_data[%0d]: got %h expected %h", got, out_data, exp_v); end
        end
        got++;
      end
      held = out_valid && !out_ready;
      hd = out_data; hc = out_carry; hz = out_zero; he = out_err;
      if (in_valid && in_ready) begin
        exp_q.push_back(32'h1 << sent);
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL bp_count: got %0d expected 4", got); end
    n_cmp++; if (stall_seen !== 1'b1) begin n_bad++; $display("FAIL bp_stall_seen: got %b expected 1", stall_seen); end
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_dup[%0d]: got valid %b expected 0", c, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h00000F00; in_shamt = 5'd4; in_mode = MODE_SRL;
    @(posedge clk); #1;
    in_data = 32'h00000003; in_shamt = 5'd2; in_mode = MODE_SLL;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_inflight: got %b expected 1", out_valid); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_async_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rmid_async_data: got %h expected 00000000", out_data); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_stale[%0d]: got %b expected 0", c, out_valid); end
    end
    @(posedge clk); #1;
    test_op("rmid_new", 32'h00000100, 5'd8, MODE_SRL, 32'h00000001, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_modes();
    test_reserved();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
